mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/rv_lsu_pkg.sv | 37 +++
 rtl/load_align.sv | 35 +++
 rtl/mem_access_unit.sv | 176 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_lsu_pkg.sv
// Shared encodings and helpers for the load/store unit: funct3 codes, FSM state
// type, bus timeout limit and store lane helpers.
package rv_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [7:0] LSU_TIMEOUT_MAX = 8'd255;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } lsu_state_e;

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3)
            F3_SB:   return 4'b0001 << addr_lo;
            F3_SH:   return 4'b0011 << {addr_lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] data);
        case (f3)
            F3_SB:   return {4{data[7:0]}};
            F3_SH:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the addressed byte/halfword out of a word-aligned
// read and sign- or zero-extends it according to funct3.
module load_align
    import rv_lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  lanes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = rdata_i[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        byte_sel = lanes[addr_lo_i];
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {24'h0, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {16'h0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage load/store unit: issues one registered data-bus request per memory op,
// stalls the pipeline until ack, and registers MEM/WB results.
// Optional bus timeout (bus_err_o) enabled by defining LSU_TIMEOUT_EN.
module mem_access_unit
    import rv_lsu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] ALUResult_i,
    input  logic [31:0] RDData_i,
    input  logic [4:0]  RDaddr_i,
    input  logic        RegWrite_i,
    input  logic        MemToReg_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] instr_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic [31:0] wb_data_o,
    output logic [4:0]  wb_rd_o,
    output logic        wb_we_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    lsu_state_e  state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic        is_load_q;
    logic        regwrite_q;
    logic        mem_to_reg_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] wb_data_q;
    logic [4:0]  wb_rd_q;
    logic        wb_we_q;
    logic        misalign_q;

    logic [2:0]  f3_d;
    logic        mem_op_d;
    logic        misaligned_d;
    logic [31:0] load_data_d;
    logic        timeout_d;
    logic        unused_instr;

    assign f3_d         = instr_i[14:12];
    assign mem_op_d     = MemRead_i | MemWrite_i;
    assign misaligned_d = (f3_d[1:0] == 2'b01 && ALUResult_i[0])
                       || (f3_d[1] && ALUResult_i[1:0] != 2'b00);
    assign unused_instr = ^{instr_i[31:15], instr_i[11:0]};

    load_align u_load_align (
        .rdata_i   (dmem_rdata_i),
        .addr_lo_i (addr_q[1:0]),
        .funct3_i  (f3_q),
        .data_o    (load_data_d)
    );

`ifdef LSU_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;
    logic       bus_err_q;

    // tmo_cnt_q == MAX-1 marks the MAX-th REQ cycle without an ack
    assign timeout_d = (state_q == ST_REQ) && !dmem_ack_i
                    && (tmo_cnt_q == LSU_TIMEOUT_MAX - 8'd1);

    always_ff @(posedge clk_i) begin
        if (rst_i || state_q != ST_REQ || timeout_d) begin
            tmo_cnt_q <= 8'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
        end
        bus_err_q <= rst_i ? 1'b0 : timeout_d;
    end

    assign bus_err_o = bus_err_q;
`else
    assign timeout_d = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    always_comb begin
        stall_o = 1'b0;
        if (state_q == ST_IDLE) begin
            stall_o = mem_op_d && !misaligned_d;
        end else begin
            stall_o = !dmem_ack_i && !timeout_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            be_q         <= 4'h0;
            f3_q         <= 3'b000;
            rd_q         <= 5'd0;
            is_load_q    <= 1'b0;
            regwrite_q   <= 1'b0;
            mem_to_reg_q <= 1'b0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            wb_data_q    <= 32'h0;
            wb_rd_q      <= 5'd0;
            wb_we_q      <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            wb_we_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mem_op_d) begin
                        if (misaligned_d) begin
                            misalign_q <= 1'b1;
                        end else begin
                            addr_q       <= ALUResult_i;
                            wdata_q      <= store_data(f3_d, RDData_i);
                            // reads always return a full aligned word, so loads enable all lanes
                            be_q         <= MemWrite_i ? store_be(f3_d, ALUResult_i[1:0]) : 4'b1111;
                            f3_q         <= f3_d;
                            rd_q         <= RDaddr_i;
                            is_load_q    <= !MemWrite_i;
                            regwrite_q   <= RegWrite_i;
                            mem_to_reg_q <= MemToReg_i;
                            req_q        <= 1'b1;
                            we_q         <= MemWrite_i;
                            state_q      <= ST_REQ;
                        end
                    end else begin
                        wb_data_q <= ALUResult_i;
                        wb_rd_q   <= RDaddr_i;
                        wb_we_q   <= RegWrite_i;
                    end
                end
                ST_REQ: begin
                    if (dmem_ack_i) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= ST_IDLE;
                        if (is_load_q) begin
                            wb_data_q <= mem_to_reg_q ? load_data_d : addr_q;
                            wb_rd_q   <= rd_q;
                            wb_we_q   <= regwrite_q;
                        end
                    end else if (timeout_d) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = {addr_q[31:2], 2'b00};
    assign dmem_wdata_o = wdata_q;
    assign dmem_be_o    = be_q;
    assign wb_data_o    = wb_data_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_we_o      = wb_we_q;
    assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: table-driven ops with a writeback
// scoreboard, plus reset-during-ack, idle-ack and timeout sequences.
module tb_mem_access_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] ALUResult_i, RDData_i, instr_i, dmem_rdata_i;
    logic [4:0]  RDaddr_i;
    logic        RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, dmem_ack_i;
    logic        dmem_req_o, dmem_we_o, stall_o, wb_we_o, misalign_o, bus_err_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, wb_data_o;
    logic [3:0]  dmem_be_o;
    logic [4:0]  wb_rd_o;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_unit dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ALUResult_i  (ALUResult_i),
        .RDData_i     (RDData_i),
        .RDaddr_i     (RDaddr_i),
        .RegWrite_i   (RegWrite_i),
        .MemToReg_i   (MemToReg_i),
        .MemRead_i    (MemRead_i),
        .MemWrite_i   (MemWrite_i),
        .instr_i      (instr_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_rdata_i (dmem_rdata_i),
        .stall_o      (stall_o),
        .wb_data_o    (wb_data_o),
        .wb_rd_o      (wb_rd_o),
        .wb_we_o      (wb_we_o),
        .misalign_o   (misalign_o),
        .bus_err_o    (bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic        mr, mw, rw, m2r;
        logic [2:0]  f3;
        logic [31:0] addr, wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          ack_after;
        logic        exp_mis;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_wb_we;
        logic [31:0] exp_wb_data;
    } vec_t;

    typedef struct packed {
        logic        we;
        logic [31:0] data;
        logic [4:0]  rd;
    } wb_t;

    wb_t  exp_q[$];
    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        wb_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL %s_sb: scoreboard empty, got wb_we=%0d", tag, wb_we_o);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_wb_we"}, 32'(wb_we_o), 32'(e.we));
        if (e.we) begin
            check({tag, "_wb_data"}, wb_data_o, e.data);
            check({tag, "_wb_rd"}, 32'(wb_rd_o), 32'(e.rd));
        end
    endtask

    task automatic drive_nop();
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        RegWrite_i  = 1'b0;
        MemToReg_i  = 1'b0;
        ALUResult_i = 32'h0;
        RDData_i    = 32'h0;
        RDaddr_i    = 5'd0;
        instr_i     = 32'h0;
        dmem_ack_i  = 1'b0;
    endtask

    task automatic drive_op(input vec_t v);
        MemRead_i         = v.mr;
        MemWrite_i        = v.mw;
        RegWrite_i        = v.rw;
        MemToReg_i        = v.m2r;
        ALUResult_i       = v.addr;
        RDData_i          = v.wdata;
        RDaddr_i          = v.rd;
        instr_i           = 32'h0;
        instr_i[14:12]    = v.f3;
        dmem_rdata_i      = v.rdata;
        dmem_ack_i        = 1'b0;
    endtask

    // Called just after a posedge; returns just after a later posedge.
    task automatic apply(input vec_t v);
        int  stalls;
        bit  acked;
        wb_t e;
        stalls = 0;
        acked  = 0;
        drive_op(v);
        e.we = v.exp_wb_we; e.data = v.exp_wb_data; e.rd = v.rd;
        exp_q.push_back(e);
        if ((v.mr || v.mw) && !v.exp_mis) begin
            @(negedge clk_i);
            stalls += int'(stall_o);
            for (int k = 1; k <= 600 && !acked; k++) begin
                @(posedge clk_i); #1;
                dmem_ack_i = (k == v.ack_after);
                @(negedge clk_i);
                stalls += int'(stall_o);
                check({v.name, "_req"}, 32'(dmem_req_o), 32'd1);
                check({v.name, "_addr"}, dmem_addr_o, v.exp_addr);
                check({v.name, "_we"}, 32'(dmem_we_o), 32'(v.mw));
                if (v.mw) begin
                    check({v.name, "_be"}, 32'(dmem_be_o), 32'(v.exp_be));
                    check({v.name, "_wdata"}, dmem_wdata_o, v.exp_wdata);
                end
                if (!dmem_ack_i) check({v.name, "_bubble"}, 32'(wb_we_o), 32'd0);
                acked = dmem_ack_i;
            end
            if (!acked) check({v.name, "_ack_bound"}, 32'd0, 32'd1);
            check({v.name, "_stall_cycles"}, 32'(stalls), 32'(v.ack_after));
            @(posedge clk_i); #1;
            drive_nop();
            @(negedge clk_i);
            check({v.name, "_req_drop"}, 32'(dmem_req_o), 32'd0);
            pop_check(v.name);
        end else begin
            @(negedge clk_i);
            check({v.name, "_stall"}, 32'(stall_o), 32'd0);
            @(posedge clk_i); #1;
            drive_nop();
            @(negedge clk_i);
            check({v.name, "_misalign"}, 32'(misalign_o), 32'(v.exp_mis));
            check({v.name, "_noreq"}, 32'(dmem_req_o), 32'd0);
            pop_check(v.name);
            if (v.exp_mis) begin
                @(posedge clk_i); #1;
                @(negedge clk_i);
                check({v.name, "_mis_pulse"}, 32'(misalign_o), 32'd0);
            end
        end
        $display("[TB] op %-10s addr=0x%08h f3=%0d done", v.name, v.addr, v.f3);
        @(posedge clk_i); #1;
    endtask

    initial begin
        //          name        mr mw rw m2r f3      addr           wdata          rd  rdata          ack mis exp_addr      be       exp_wdata      wbwe wb_data
        vecs[0]  = '{"alu_rd5",   0, 0, 1, 0, 3'b000, 32'h0000_1234, 32'h0,         5,  32'h0,         0, 0, 32'h0,       4'h0,    32'h0,         1, 32'h0000_1234};
        vecs[1]  = '{"lb_103",    1, 0, 1, 1, 3'b000, 32'h0000_0103, 32'h0,         7,  32'h80FF_FFFF, 3, 0, 32'h100,     4'h0,    32'h0,         1, 32'hFFFF_FF80};
        vecs[2]  = '{"sh_22",     0, 1, 0, 0, 3'b001, 32'h0000_0022, 32'hABCD_1234, 0,  32'h0,         1, 0, 32'h20,      4'b1100, 32'h1234_1234, 0, 32'h0};
        vecs[3]  = '{"lw_06",     1, 0, 1, 1, 3'b010, 32'h0000_0006, 32'h0,         9,  32'h0,         0, 1, 32'h0,       4'h0,    32'h0,         0, 32'h0};
        vecs[4]  = '{"lbu_101",   1, 0, 1, 1, 3'b100, 32'h0000_0101, 32'h0,         10, 32'h1234_80AB, 2, 0, 32'h100,     4'h0,    32'h0,         1, 32'h0000_0080};
        vecs[5]  = '{"lh_102",    1, 0, 1, 1, 3'b001, 32'h0000_0102, 32'h0,         11, 32'h8001_7FFF, 1, 0, 32'h100,     4'h0,    32'h0,         1, 32'hFFFF_8001};
        vecs[6]  = '{"lhu_100",   1, 0, 1, 1, 3'b101, 32'h0000_0100, 32'h0,         12, 32'h8001_F00D, 4, 0, 32'h100,     4'h0,    32'h0,         1, 32'h0000_F00D};
        vecs[7]  = '{"lw_40",     1, 0, 1, 1, 3'b010, 32'h0000_0040, 32'h0,         31, 32'hDEAD_BEEF, 1, 0, 32'h40,      4'h0,    32'h0,         1, 32'hDEAD_BEEF};
        vecs[8]  = '{"sb_13",     0, 1, 0, 0, 3'b000, 32'h0000_0013, 32'h0000_00A5, 0,  32'h0,         2, 0, 32'h10,      4'b1000, 32'hA5A5_A5A5, 0, 32'h0};
        vecs[9]  = '{"sw_44",     0, 1, 0, 0, 3'b010, 32'h0000_0044, 32'hCAFE_F00D, 0,  32'h0,         1, 0, 32'h44,      4'b1111, 32'hCAFE_F00D, 0, 32'h0};
        vecs[10] = '{"sh_21",     0, 1, 0, 0, 3'b001, 32'h0000_0021, 32'h5555_AAAA, 0,  32'h0,         0, 1, 32'h0,       4'h0,    32'h0,         0, 32'h0};
        vecs[11] = '{"lb_rw0",    1, 0, 0, 1, 3'b000, 32'h0000_0002, 32'h0,         3,  32'h0055_0000, 1, 0, 32'h0,       4'h0,    32'h0,         0, 32'h0};
        vecs[12] = '{"alu_rw0",   0, 0, 0, 0, 3'b000, 32'hFFFF_FFFF, 32'h0,         0,  32'h0,         0, 0, 32'h0,       4'h0,    32'h0,         0, 32'h0};
        vecs[13] = '{"sb_200",    0, 1, 0, 0, 3'b000, 32'h0000_0200, 32'h1234_5678, 0,  32'h0,         1, 0, 32'h200,     4'b0001, 32'h7878_7878, 0, 32'h0};
        vecs[14] = '{"lw_03",     1, 0, 1, 1, 3'b010, 32'h0000_0003, 32'h0,         4,  32'h0,         0, 1, 32'h0,       4'h0,    32'h0,         0, 32'h0};

        rst_i        = 1'b1;
        dmem_rdata_i = 32'h0;
        drive_nop();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_req", 32'(dmem_req_o), 32'd0);
        check("rst_addr", dmem_addr_o, 32'h0);
        check("rst_be", 32'(dmem_be_o), 32'd0);
        check("rst_wb", {wb_data_o[31:6], wb_rd_o, wb_we_o}, 32'h0);
        check("rst_faults", {30'h0, misalign_o, bus_err_o}, 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_stall", 32'(stall_o), 32'd0);
        @(posedge clk_i); #1;

        for (int i = 0; i < 15; i++) apply(vecs[i]);

        // ack while idle must not start anything
        dmem_ack_i = 1'b1;
        @(negedge clk_i);
        check("idle_ack_stall", 32'(stall_o), 32'd0);
        @(posedge clk_i); #1;
        dmem_ack_i = 1'b0;
        @(negedge clk_i);
        check("idle_ack_req", 32'(dmem_req_o), 32'd0);
        $display("[TB] op idle_ack done");
        @(posedge clk_i); #1;

        // reset coincident with ack discards the in-flight load
        drive_op(vecs[7]);
        RDaddr_i = 5'd17;
        @(posedge clk_i); #1;
        rst_i      = 1'b1;
        dmem_ack_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        drive_nop();
        @(negedge clk_i);
        check("rst_ack_req", 32'(dmem_req_o), 32'd0);
        check("rst_ack_wb_we", 32'(wb_we_o), 32'd0);
        check("rst_ack_stall", 32'(stall_o), 32'd0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("rst_ack_idle", {30'h0, dmem_req_o, wb_we_o}, 32'h0);
        $display("[TB] op rst_ack done");
        @(posedge clk_i); #1;

        // unacknowledged load
        drive_op(vecs[7]);
`ifdef LSU_TIMEOUT_EN
        begin
            int req_cycles;
            bit released;
            req_cycles = 0;
            released   = 0;
            for (int k = 1; k <= 400 && !released; k++) begin
                @(posedge clk_i); #1;
                @(negedge clk_i);
                req_cycles = k;
                released   = !stall_o;
            end
            check("tmo_req_cycles", 32'(req_cycles), 32'd255);
            @(posedge clk_i); #1;
            drive_nop();
            @(negedge clk_i);
            check("tmo_bus_err", 32'(bus_err_o), 32'd1);
            check("tmo_wb_we", 32'(wb_we_o), 32'd0);
            check("tmo_req", 32'(dmem_req_o), 32'd0);
            check("tmo_stall", 32'(stall_o), 32'd0);
            @(posedge clk_i); #1;
            @(negedge clk_i);
            check("tmo_pulse", 32'(bus_err_o), 32'd0);
            $display("[TB] op timeout done after %0d REQ cycles", req_cycles);
        end
`else
        begin
            int drops;
            int errs;
            drops = 0;
            errs  = 0;
            for (int k = 1; k <= 300; k++) begin
                @(posedge clk_i); #1;
                @(negedge clk_i);
                drops += int'(!stall_o);
                errs  += int'(bus_err_o);
            end
            check("wait_stall_drops", 32'(drops), 32'd0);
            check("wait_bus_err", 32'(errs), 32'd0);
            check("wait_req", 32'(dmem_req_o), 32'd1);
            @(posedge clk_i); #1;
            dmem_ack_i = 1'b1;
            @(posedge clk_i); #1;
            drive_nop();
            @(negedge clk_i);
            check("wait_wb_data", wb_data_o, 32'hDEAD_BEEF);
            check("wait_wb_we", 32'(wb_we_o), 32'd1);
            $display("[TB] op long_wait done");
        end
`endif
        @(posedge clk_i); #1;

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
